onehot_vec_monitor: RTL
=======================

# onehot_vec_monitor

Registered, parametrised one-hot legality monitor for a WIDTH-bit select/grant/state vector. It checks each valid sample against one-hot or one-hot-or-zero rules, selectable at run time, and encodes the set bit to a binary index. It counts violations, detects stalls caused by long runs of all-zero vectors, and holds a sticky fault until cleared. It sits beside arbiters and one-hot FSMs as a synthesizable companion to the `$onehot`/`$onehot0` assertions.

## Interface
- WIDTH, 4, monitored vector width (≥2)
- CNT_W, 8, width of violation counter and sample timestamp
- ZERO_TIMEOUT, 4, consecutive valid all-zero samples that raise zero_stall (≥1, < 2^CNT_W)
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  1 = monitoring armed; 0 = samples ignored
- allow_zero  in  1  0 = strict one-hot; 1 = one-hot-or-zero
- vec_valid  in  1  vec is a sample this cycle
- vec  in  WIDTH  vector under check
- clr  in  1  clears err_cnt, err_sticky, zero_stall, and returns FAULT to MONITOR
- ok  out  1  last accepted sample legal
- idx  out  $clog2(WIDTH)  index of set bit of last legal non-zero sample
- idx_valid  out  1  idx updated by last accepted sample
- err_sticky  out  1  at least one violation since reset/clr
- err_cnt  out  CNT_W  violation count, saturating at all-ones
- zero_stall  out  1  zero-run reached ZERO_TIMEOUT
- state  out  2  0 = IDLE, 1 = MONITOR, 2 = FAULT

## Operation
- Accepted sample: `vec_valid & en` while in state MONITOR or FAULT.
- Legality:
  - popcount(vec) == 1 is always legal.
  - popcount == 0 is legal only when allow_zero = 1.
  - popcount ≥ 2 is always illegal.
- Each accepted sample updates ok.
- idx_valid = 1 only for a legal sample with popcount 1, and idx is loaded from it; otherwise idx holds its value and idx_valid = 0.
- Violation: err_cnt += 1 (saturating), err_sticky = 1, state → FAULT.
- FSM:
  - IDLE → MONITOR when en = 1.
  - MONITOR → FAULT on a violation.
  - FAULT → MONITOR on clr.
  - Any state → IDLE when en = 0; counters and flags hold.
- Zero-run counter:
  - Increments on each accepted all-zero sample while allow_zero = 1.
  - Resets on an accepted non-zero sample, or when allow_zero = 0.
  - zero_stall sets when the count reaches ZERO_TIMEOUT and stays set until a non-zero accepted sample or clr.
  - The counter saturates at ZERO_TIMEOUT.
- Non-accepted cycles leave every output unchanged, except idx_valid, which goes to 0.

## Timing
- All outputs registered; 1-cycle latency from sample to ok/idx/err_cnt/state.
- Reset values: ok = 1, idx = 0, idx_valid = 0, err_sticky = 0, err_cnt = 0, zero_stall = 0, state = IDLE, internal counters 0.
- rst_n = 0 overrides everything, including mid-run and mid-FAULT.
- clr and a violation in the same cycle: the clear applies first, then the violation is counted. Result: err_cnt = 1, err_sticky = 1, state = FAULT.
- clr alone: err_cnt = 0, err_sticky = 0, zero_stall = 0, zero-run = 0, FAULT → MONITOR next cycle.
- en rising: the first sample is accepted one cycle after entering MONITOR. The IDLE cycle ignores vec_valid.
- err_cnt at 2^CNT_W−1 stays there; err_sticky still 1.
- allow_zero may change on any cycle and applies to the same-cycle sample.

## Configuration
- ONEHOT_VEC_MONITOR_CAPTURE_EN defined:
  - Adds outputs cap_vec [WIDTH] and cap_time [CNT_W].
  - A free-running CNT_W accepted-sample counter (wrapping) runs alongside the monitor.
  - On the first violation after reset/clr, cap_vec and cap_time latch the offending vector and the counter value.
  - Later violations do not overwrite them until clr.
  - Reset values of cap_vec, cap_time and the sample counter are 0.
- Undefined: these ports, the counter and the capture registers are absent; all other behaviour is identical.

## Structure
- Shared package onehot_mon_pkg: state enum (IDLE/MONITOR/FAULT), popcount classification enum (ZERO/ONE/MULTI).
- One sub-module, onehot_vec_classify: combinational popcount classifier plus priority index encoder.
- Top: FSM, counters, capture registers.

## Test plan
- WIDTH = 4, en = 1, allow_zero = 0, vec = 4'b0100 → next cycle ok = 1, idx = 2, idx_valid = 1, state = MONITOR.
- vec = 4'b0110 → ok = 0, err_cnt = 1, err_sticky = 1, state = FAULT; with capture on, cap_vec = 4'b0110.
- allow_zero = 1, four consecutive vec = 0 with ZERO_TIMEOUT = 4 → zero_stall = 1 after the 4th; next vec = 4'b0001 clears it; ok stays 1 throughout.
- allow_zero = 0, vec = 0 → violation; then clr together with vec = 4'b1111 → err_cnt = 1, state = FAULT.
- CNT_W = 2, five violations → err_cnt saturates at 3; clr → err_cnt = 0, state = MONITOR.
- rst_n low for 1 cycle during FAULT → all outputs return to reset values, state = IDLE.

Source files
------------

// File: rtl/onehot_mon_pkg.sv
// Shared types for the one-hot vector monitor: FSM state encoding and the
// popcount classification produced by the classifier.
package onehot_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } pop_class_e;

endpackage

// File: rtl/onehot_vec_classify.sv
// Combinational popcount classifier (zero / one / more than one bit set)
// plus a priority encoder returning the lowest set bit index.
module onehot_vec_classify
    import onehot_mon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec,
    output pop_class_e               cls,
    output logic [$clog2(WIDTH)-1:0] enc
);

    // Count set bits (saturating at 2, which is all we need) and find the lowest one.
    always_comb begin
        logic [1:0] cnt;
        cnt = 2'd0;
        enc = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                enc = i[$clog2(WIDTH)-1:0];
                if (cnt != 2'd2) begin
                    cnt = cnt + 2'd1;
                end
            end
        end
        case (cnt)
            2'd0:    cls = ZERO;
            2'd1:    cls = ONE;
            default: cls = MULTI;
        endcase
    end

endmodule

// File: rtl/onehot_vec_monitor.sv
// Registered one-hot legality monitor with violation counting, zero-run
// stall detection and a sticky fault FSM.
// Optional feature macro: ONEHOT_VEC_MONITOR_CAPTURE_EN adds cap_vec/cap_time,
// which latch the first offending vector and its accepted-sample timestamp.
module onehot_vec_monitor
    import onehot_mon_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CNT_W        = 8,
    parameter int ZERO_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     allow_zero,
    input  logic                     vec_valid,
    input  logic [WIDTH-1:0]         vec,
    input  logic                     clr,
    output logic                     ok,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     idx_valid,
    output logic                     err_sticky,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     zero_stall,
`ifdef ONEHOT_VEC_MONITOR_CAPTURE_EN
    output logic [WIDTH-1:0]         cap_vec,
    output logic [CNT_W-1:0]         cap_time,
`endif
    output logic [1:0]               state
);

    localparam int              IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] ZT_C = CNT_W'(ZERO_TIMEOUT);
    localparam logic [CNT_W-1:0] SAT_C = '1;

    pop_class_e       cls;
    logic [IDX_W-1:0] enc;

    mon_state_e       state_q, state_d;
    logic             ok_q, ok_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             idx_valid_q, idx_valid_d;
    logic             err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             zero_stall_q, zero_stall_d;
    logic [CNT_W-1:0] zrun_q, zrun_d;
    logic             accepted, legal, violation;
`ifdef ONEHOT_VEC_MONITOR_CAPTURE_EN
    logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
    logic [WIDTH-1:0] cap_vec_q, cap_vec_d;
    logic [CNT_W-1:0] cap_time_q, cap_time_d;
    logic             cap_done_q, cap_done_d;
`endif

    onehot_vec_classify #(.WIDTH(WIDTH)) u_classify (
        .vec (vec),
        .cls (cls),
        .enc (enc)
    );

    // Sample acceptance, legality, counters and flags; clr is applied before
    // the same-cycle sample so a coincident violation still counts.
    always_comb begin
        ok_d         = ok_q;
        idx_d        = idx_q;
        idx_valid_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_cnt_d    = err_cnt_q;
        zero_stall_d = zero_stall_q;
        zrun_d       = zrun_q;

        accepted  = vec_valid & en & (state_q != IDLE);
        legal     = (cls == ONE) | ((cls == ZERO) & allow_zero);
        violation = accepted & ~legal;

        if (clr) begin
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
            zero_stall_d = 1'b0;
            zrun_d       = '0;
        end
        if (!allow_zero) begin
            zrun_d = '0;
        end
        if (accepted) begin
            ok_d = legal;
            if (cls == ZERO) begin
                if (allow_zero) begin
                    if (zrun_d != ZT_C) begin
                        zrun_d = zrun_d + 1'b1;
                    end
                    if (zrun_d == ZT_C) begin
                        zero_stall_d = 1'b1;
                    end
                end
            end else begin
                zrun_d       = '0;
                zero_stall_d = 1'b0;
                if (cls == ONE) begin
                    idx_d       = enc;
                    idx_valid_d = 1'b1;
                end
            end
            if (violation) begin
                if (err_cnt_d != SAT_C) begin
                    err_cnt_d = err_cnt_d + 1'b1;
                end
                err_sticky_d = 1'b1;
            end
        end
    end

    // Next-state logic; en low forces IDLE from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = MONITOR;
            MONITOR: if (violation) state_d = FAULT;
            FAULT:   if (clr && !violation) state_d = MONITOR;
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
        end
    end

`ifdef ONEHOT_VEC_MONITOR_CAPTURE_EN
    // Accepted-sample timestamp and first-violation capture, rearmed by clr.
    always_comb begin
        smp_cnt_d  = smp_cnt_q + CNT_W'(accepted);
        cap_vec_d  = cap_vec_q;
        cap_time_d = cap_time_q;
        cap_done_d = cap_done_q & ~clr;
        if (violation && !cap_done_d) begin
            cap_vec_d  = vec;
            cap_time_d = smp_cnt_q;
            cap_done_d = 1'b1;
        end
    end

    // Capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            smp_cnt_q  <= '0;
            cap_vec_q  <= '0;
            cap_time_q <= '0;
            cap_done_q <= 1'b0;
        end else begin
            smp_cnt_q  <= smp_cnt_d;
            cap_vec_q  <= cap_vec_d;
            cap_time_q <= cap_time_d;
            cap_done_q <= cap_done_d;
        end
    end

    assign cap_vec  = cap_vec_q;
    assign cap_time = cap_time_q;
`endif

    // Monitor state and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ok_q         <= 1'b1;
            idx_q        <= '0;
            idx_valid_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            zero_stall_q <= 1'b0;
            zrun_q       <= '0;
        end else begin
            state_q      <= state_d;
            ok_q         <= ok_d;
            idx_q        <= idx_d;
            idx_valid_q  <= idx_valid_d;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            zero_stall_q <= zero_stall_d;
            zrun_q       <= zrun_d;
        end
    end

    assign ok         = ok_q;
    assign idx        = idx_q;
    assign idx_valid  = idx_valid_q;
    assign err_sticky = err_sticky_q;
    assign err_cnt    = err_cnt_q;
    assign zero_stall = zero_stall_q;
    assign state      = state_q;

endmodule
